conv2_stream: RTL and testbench

- Streaming, parametrised successor to conv2: 2D valid-mode convolution of a SIZE x SIZE image with a runtime-loadable SIZEKer x SIZEKer kernel.
- Pixels arrive raster-order over valid/ready rather than as a full matrix port.
- Line buffers hold SIZEKer-1 rows. Adds configurable stride, fixed-point shift, saturation and output backpressure.
- Sits between a pixel source (memory reader/camera) and downstream layers of the ConvNet pipeline.

---
 rtl/conv2_stream_pkg.sv | 46 ++++
 rtl/conv2_stream_if.sv | 41 ++++
 rtl/conv2_stream_line_buffer.sv | 42 ++++
 rtl/conv2_stream.sv | 196 +++++++++++++++++++
 tb/tb_conv2_stream.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2_stream_pkg.sv
// rtl/conv2_stream_pkg.sv - shared types and helpers for the conv2_stream slice
//
// Purpose: FSM state enum, output-grid / accumulator / address width helpers
// and the signed saturation function used by conv2_stream.
// Ports: none (package).
// Optional feature macro used elsewhere in the slice: CONV2_RELU_EN.

package conv2_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Common width used to carry accumulators through saturation.
  localparam int SAT_W = 64;

  // Output grid edge length for a valid-mode convolution with stride.
  function automatic int out_dim(input int size, input int k, input int stride);
    return (size - k) / stride + 1;
  endfunction

  // Accumulator width: full product width plus growth for K*K terms.
  function automatic int acc_w(input int w, input int k);
    return 2 * w + $clog2(k * k);
  endfunction

  // Coefficient address width, never narrower than one bit.
  function automatic int addr_w(input int k);
    return (k * k > 1) ? $clog2(k * k) : 1;
  endfunction

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                      input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv2_stream_if.sv
// rtl/conv2_stream_if.sv - control, kernel-load and stream bus of conv2_stream
//
// Purpose: groups the frame control, coefficient write port, pixel input
// stream and result output stream.
// Signals: start, ker_we/ker_addr/ker_data, pix_valid/pix_ready/pix_data,
// out_valid/out_ready/out_data/out_last, busy, done.
// Modports: master (pixel source / controller side), slave (conv2_stream).

interface conv2_stream_if
  import conv2_stream_pkg::*;
#(
  parameter int WIDTH_BIT = 16,
  parameter int SIZEKer   = 3
);
  localparam int KA_W = addr_w(SIZEKer);

  logic                 start;
  logic                 ker_we;
  logic [KA_W-1:0]      ker_addr;
  logic [WIDTH_BIT-1:0] ker_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [WIDTH_BIT-1:0] pix_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_BIT-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, ker_we, ker_addr, ker_data, pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, ker_we, ker_addr, ker_data, pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/conv2_stream_line_buffer.sv
// rtl/conv2_stream_line_buffer.sv - (SIZEKer-1) row line buffer producing one tap column
//
// Purpose: shift chain of (SIZEKer-1)*SIZE pixels advanced once per accepted
// pixel. Tap m is the pixel m rows above the incoming one in the same column.
// Ports: clock, reset (async active-high), shift_en_i (advance chain),
// pix_i (incoming pixel), taps_o[m] (m=0 incoming row, m=SIZEKer-1 oldest row).

module conv2_stream_line_buffer #(
  parameter int SIZE      = 100,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              shift_en_i,
  input  logic [WIDTH_BIT-1:0]              pix_i,
  output logic [SIZEKer-1:0][WIDTH_BIT-1:0] taps_o
);

  assign taps_o[0] = pix_i;

  if (SIZEKer > 1) begin : g_buf
    localparam int DEPTH = (SIZEKer - 1) * SIZE;

    logic [WIDTH_BIT-1:0] line_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else if (shift_en_i) begin
        line_q[0] <= pix_i;
        for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      end
    end

    // Exactly SIZE pixels separate vertically adjacent samples in raster order.
    for (genvar m = 1; m < SIZEKer; m++) begin : g_tap
      assign taps_o[m] = line_q[m*SIZE-1];
    end
  end

endmodule

// File: rtl/conv2_stream.sv
// rtl/conv2_stream.sv - streaming SIZE x SIZE valid-mode 2D convolution with loadable kernel
//
// Purpose: accepts raster-order pixels, forms the SIZEKer x SIZEKer window
// ending at the current pixel, and emits strided, shifted, saturated results.
// Ports: clock, reset (async active-high), bus (conv2_stream_if.slave:
// start, ker_we/ker_addr/ker_data, pix_valid/pix_ready/pix_data,
// out_valid/out_ready/out_data/out_last, busy, done).
// Build option: CONV2_RELU_EN clamps negative results to zero after saturation.

module conv2_stream
  import conv2_stream_pkg::*;
#(
  parameter int SIZE      = 100,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  parameter int STRIDE    = 1,
  parameter int SHIFT     = 0
) (
  input logic           clock,
  input logic           reset,
  conv2_stream_if.slave bus
);

  localparam int KK       = SIZEKer * SIZEKer;
  localparam int OUT      = out_dim(SIZE, SIZEKer, STRIDE);
  localparam int ACC_W    = acc_w(WIDTH_BIT, SIZEKer);
  localparam int RC_W     = $clog2(SIZE + 1);
  localparam int LAST_OFF = (OUT - 1) * STRIDE;
  localparam logic [RC_W-1:0] EDGE = RC_W'(SIZE - 1);

  state_e state_q, state_d;
  logic [RC_W-1:0] row_q, row_d, col_q, col_d;
  logic pix_done_q, pix_done_d;
  logic last_sent_q, last_sent_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic [WIDTH_BIT-1:0] out_data_q, out_data_d;

  logic signed [WIDTH_BIT-1:0] ker_q [KK];
  logic signed [WIDTH_BIT-1:0] win_q [SIZEKer][SIZEKer];
  logic signed [WIDTH_BIT-1:0] win_d [SIZEKer][SIZEKer];
  logic [SIZEKer-1:0][WIDTH_BIT-1:0] taps;

  logic pix_ready, accept, out_hs, final_pix, emit, is_last;
  int   r_off, c_off;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_sh;
  logic signed [SAT_W-1:0] sat;
  logic [WIDTH_BIT-1:0] res;

  // A new pixel may only enter if its possible result has somewhere to go.
  assign pix_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready) && !pix_done_q;
  assign accept    = bus.pix_valid && pix_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign final_pix = (row_q == EDGE) && (col_q == EDGE);

  conv2_stream_line_buffer #(
    .SIZE      (SIZE),
    .SIZEKer   (SIZEKer),
    .WIDTH_BIT (WIDTH_BIT)
  ) u_line_buffer (
    .clock      (clock),
    .reset      (reset),
    .shift_en_i (accept),
    .pix_i      (bus.pix_data),
    .taps_o     (taps)
  );

  // Window row 0 is the oldest image row, column SIZEKer-1 the newest column.
  always_comb begin
    for (int i = 0; i < SIZEKer; i++)
      for (int j = 0; j < SIZEKer; j++)
        win_d[i][j] = win_q[i][j];
    if (accept) begin
      for (int i = 0; i < SIZEKer; i++) begin
        for (int j = 0; j < SIZEKer - 1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][SIZEKer-1] = taps[SIZEKer-1-i];
      end
    end
  end

  // The result is formed from the window including the pixel being accepted,
  // so it can be registered in the same cycle.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < SIZEKer; i++) begin
      for (int j = 0; j < SIZEKer; j++) begin
        prod = (2*WIDTH_BIT)'(win_d[i][j]) * (2*WIDTH_BIT)'(ker_q[i*SIZEKer+j]);
        acc  = acc + ACC_W'(prod);
      end
    end
    acc_sh = acc >>> SHIFT;
    sat    = saturate(SAT_W'(acc_sh), WIDTH_BIT);
    res    = WIDTH_BIT'(sat);
`ifdef CONV2_RELU_EN
    if (res[WIDTH_BIT-1]) res = '0;
`endif
  end

  // Offsets of the current pixel from the first complete window position.
  always_comb begin
    r_off   = int'(row_q) - (SIZEKer - 1);
    c_off   = int'(col_q) - (SIZEKer - 1);
    emit    = (r_off >= 0) && (c_off >= 0) && (r_off % STRIDE == 0) && (c_off % STRIDE == 0);
    is_last = (r_off == LAST_OFF) && (c_off == LAST_OFF);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_done_d  = pix_done_q;
    last_sent_d = last_sent_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          row_d       = '0;
          col_d       = '0;
          pix_done_d  = 1'b0;
          last_sent_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_q == EDGE) begin
            col_d = '0;
            if (row_q == EDGE) pix_done_d = 1'b1;
            else               row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_last_d  = is_last;
          end
        end
        if (out_hs && out_last_q) last_sent_d = 1'b1;
        // Trailing pixels past the last stride position are still drained, so
        // the frame ends only once both the input and the output side are done.
        if ((pix_done_q || (accept && final_pix)) && (last_sent_q || (out_hs && out_last_q)))
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pix_done_q  <= 1'b0;
      last_sent_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < SIZEKer; i++)
        for (int j = 0; j < SIZEKer; j++)
          win_q[i][j] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_done_q  <= pix_done_d;
      last_sent_q <= last_sent_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  // Coefficients are writable only between frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KK; k++) ker_q[k] <= '0;
    end else if (bus.ker_we && state_q != ST_RUN) begin
      for (int k = 0; k < KK; k++)
        if (int'(bus.ker_addr) == k) ker_q[k] <= bus.ker_data;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv2_stream.sv
// tb/tb_conv2_stream.sv - scoreboard bench for conv2_stream (two configurations)

module tb_conv2_stream;

  localparam int W   = 16;
  localparam int K   = 3;
  localparam int SZ0 = 5;
  localparam int ST0 = 1;
  localparam int SH0 = 0;
  localparam int SZ1 = 6;
  localparam int ST1 = 2;
  localparam int SH1 = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  conv2_stream_if #(.WIDTH_BIT(W), .SIZEKer(K)) bus0 ();
  conv2_stream_if #(.WIDTH_BIT(W), .SIZEKer(K)) bus1 ();

  conv2_stream #(.SIZE(SZ0), .SIZEKer(K), .WIDTH_BIT(W), .STRIDE(ST0), .SHIFT(SH0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  conv2_stream #(.SIZE(SZ1), .SIZEKer(K), .WIDTH_BIT(W), .STRIDE(ST1), .SHIFT(SH1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  logic         sel;
  logic         start, ker_we, pix_valid, out_ready;
  logic [3:0]   ker_addr;
  logic [W-1:0] ker_data, pix_data;
  logic         pix_ready, out_valid, out_last, busy, done;
  logic [W-1:0] out_data;

  assign bus0.start     = start & ~sel;
  assign bus1.start     = start & sel;
  assign bus0.ker_we    = ker_we & ~sel;
  assign bus1.ker_we    = ker_we & sel;
  assign bus0.ker_addr  = ker_addr;
  assign bus1.ker_addr  = ker_addr;
  assign bus0.ker_data  = ker_data;
  assign bus1.ker_data  = ker_data;
  assign bus0.pix_valid = pix_valid & ~sel;
  assign bus1.pix_valid = pix_valid & sel;
  assign bus0.pix_data  = pix_data;
  assign bus1.pix_data  = pix_data;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  assign pix_ready = sel ? bus1.pix_ready : bus0.pix_ready;
  assign out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign out_data  = sel ? bus1.out_data  : bus0.out_data;
  assign out_last  = sel ? bus1.out_last  : bus0.out_last;
  assign busy      = sel ? bus1.busy      : bus0.busy;
  assign done      = sel ? bus1.done      : bus0.done;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: direct definition of strided valid convolution.
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   img [SZ1*SZ1];
  int   ker [K*K];

  task automatic push_expected(input int sz, input int stride, input int shift);
    int     od;
    longint acc;
    exp_t   e;
    od = (sz - K) / stride + 1;
    for (int orow = 0; orow < od; orow++) begin
      for (int ocol = 0; ocol < od; ocol++) begin
        acc = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += longint'(img[(orow*stride+i)*sz + ocol*stride + j]) * longint'(ker[i*K+j]);
        acc = acc >>> shift;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef CONV2_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.data = W'(acc);
        e.last = (orow == od - 1) && (ocol == od - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Output-ready policy: 0 always ready, 1 random, 2 stall 10 cycles after 2nd output.
  int rmode = 0;
  int hs_cnt = 0;
  int stall_left = 0;
  bit stall_done = 0;
  int stall_obs = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (!stall_done && hs_cnt == 2) begin
            out_ready  = 1'b0;
            stall_left = 9;
            stall_done = 1;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  bit           hold_pending = 0;
  logic [W-1:0] hold_data;
  logic         hold_last;

  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      if (rmode == 2 && !out_ready && out_valid) begin
        check("bp_pix_ready", pix_ready, 0);
        stall_obs++;
      end
      if (out_valid && out_ready) begin
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
        hs_cnt++;
        hold_pending = 0;
      end else if (out_valid) begin
        hold_pending = 1;
        hold_data    = out_data;
        hold_last    = out_last;
      end else begin
        hold_pending = 0;
      end
    end
  end

  task automatic load_kernel();
    for (int i = 0; i < K*K; i++) begin
      ker_we   = 1'b1;
      ker_addr = 4'(i);
      ker_data = W'(ker[i]);
      @(posedge clock);
      #1;
    end
    ker_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // poke: mid-frame kernel write and start pulse, both of which must be ignored.
  task automatic send_pixels(input int n, input bit poke);
    for (int idx = 0; idx < n; idx++) begin
      int gap;
      int waited;
      bit got;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
      if (poke && idx == 4) begin
        ker_we   = 1'b1;
        ker_addr = 4'd4;
        ker_data = 16'h0007;
        start    = 1'b1;
        @(posedge clock);
        #1;
        ker_we = 1'b0;
        start  = 1'b0;
      end
      pix_valid = 1'b1;
      pix_data  = W'(img[idx]);
      waited    = 0;
      got       = 0;
      while (!got && waited < 300) begin
        @(negedge clock);
        got = pix_ready;
        waited++;
      end
      check("pix_accept_in_time", got, 1);
      @(posedge clock);
      #1;
      pix_valid = 1'b0;
      if (!got) return;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("done_set", done, 1);
    check("done_busy_low", busy, 0);
    check("done_pix_ready_low", pix_ready, 0);
    check("done_out_valid_low", out_valid, 0);
    check("sb_drained", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input bit s, input bit load, input bit poke);
    int sz;
    sel = s;
    sz  = s ? SZ1 : SZ0;
    if (load) load_kernel();
    push_expected(sz, s ? ST1 : ST0, s ? SH1 : SH0);
    hs_cnt     = 0;
    stall_done = 0;
    pulse_start();
    check("busy_in_run", busy, 1);
    send_pixels(sz * sz, poke);
    wait_done();
  endtask

  task automatic set_ramp(input int sz);
    for (int i = 0; i < sz * sz; i++) img[i] = i;
  endtask

  task automatic set_const_img(input int v);
    for (int i = 0; i < SZ1 * SZ1; i++) img[i] = v;
  endtask

  task automatic set_ident();
    for (int i = 0; i < K*K; i++) ker[i] = (i == (K*K)/2) ? 1 : 0;
  endtask

  task automatic set_const_ker(input int v);
    for (int i = 0; i < K*K; i++) ker[i] = v;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    start     = 1'b0;
    ker_we    = 1'b0;
    ker_addr  = '0;
    ker_data  = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Identity kernel on a ramp image.
    set_ramp(SZ0); set_ident();
    run_frame(0, 1, 1);
    // All-ones kernel and image.
    set_const_img(1); set_const_ker(1);
    run_frame(0, 1, 0);
    // Positive and negative saturation.
    set_const_img(32767); set_const_ker(1);
    run_frame(0, 1, 0);
    set_const_ker(-1);
    run_frame(0, 1, 0);

    // Output backpressure after the 2nd result.
    set_ramp(SZ0); set_ident();
    rmode     = 2;
    stall_obs = 0;
    run_frame(0, 1, 0);
    check("bp_stall_seen", stall_obs >= 5, 1);
    rmode = 0;

    // Reset in the middle of a frame.
    sel = 0;
    load_kernel();
    pulse_start();
    send_pixels(7, 0);
    reset = 1'b1;
    #1;
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    // Kernel was cleared by reset: every result is zero until reloaded.
    set_const_ker(0);
    run_frame(0, 0, 0);
    set_ident();
    run_frame(0, 1, 0);

    // Stride 2, shift 1, trailing row/column drained.
    set_ramp(SZ1); set_ident();
    run_frame(1, 1, 1);
    set_const_img(32767); set_const_ker(1);
    run_frame(1, 1, 0);
    set_const_ker(-1);
    run_frame(1, 1, 0);

    // Randomised frames on both configurations with random backpressure.
    rmode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < K*K; i++) ker[i] = $urandom_range(0, 8) - 4;
      for (int i = 0; i < SZ1*SZ1; i++) img[i] = $urandom_range(0, 65535) - 32768;
      run_frame(f % 2, 1, (f == 2));
    end
    rmode = 0;

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
